// File: rtl/train_dispatch.sv
// train_dispatch: turns push/pop ops into a stack-legal departure pattern sent as N then order[0..N-1]; in clk rst op_valid op op_last, out op_ready tx_valid tx_data done err
module train_dispatch #(
  parameter int MAX_CARS = 10,
  parameter int DATA_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic op_valid,
  input  logic op,
  input  logic op_last,
  output logic op_ready,
  output logic tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic done,
  output logic err
);
  localparam int CW = $clog2(MAX_CARS + 1);
  typedef enum logic [2:0] {COLLECT, EVAL, SEND, DONE, ERR} state_t;
  state_t state, state_n;
  logic [CW-1:0] sp, push_cnt, pop_cnt, idx;
  logic flag, acc, clr;
  logic [DATA_W-1:0] stack [MAX_CARS];
  logic [DATA_W-1:0] order [MAX_CARS];
  logic op_ready_d, tx_valid_d, done_d, err_d;
  logic [DATA_W-1:0] tx_data_d;
  assign acc = state == COLLECT && op_valid;
  assign clr = state == DONE || state == ERR;
  always_ff @(posedge clk)
    if (rst) begin
      state <= COLLECT;
      op_ready <= 1'b1;
      tx_valid <= 1'b0;
      tx_data <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      op_ready <= op_ready_d;
      tx_valid <= tx_valid_d;
      tx_data <= tx_data_d;
      done <= done_d;
      err <= err_d;
    end
  always_comb
    state_n = state == COLLECT ? (acc && op_last ? EVAL : COLLECT) :
              state == EVAL    ? (flag || sp != '0 || push_cnt == '0 ? ERR : SEND) :
              state == SEND    ? (idx == push_cnt ? DONE : SEND) : COLLECT;
  always_comb begin
    op_ready_d = state_n == COLLECT;
    tx_valid_d = state_n == SEND;
    done_d = state_n == DONE;
    err_d = state_n == ERR;
    tx_data_d = state_n != SEND ? '0 : state == EVAL ? DATA_W'(push_cnt) : order[idx];
  end
  always_ff @(posedge clk)
    if (rst || clr) begin
      sp <= '0;
      push_cnt <= '0;
      pop_cnt <= '0;
      idx <= '0;
      flag <= 1'b0;
    end else if (acc && !flag) begin
      if (op) begin
        if (push_cnt == CW'(MAX_CARS)) flag <= 1'b1;
        else begin
          stack[sp] <= DATA_W'(push_cnt + 1'b1);
          sp <= sp + 1'b1;
          push_cnt <= push_cnt + 1'b1;
        end
      end else if (sp == '0) flag <= 1'b1;
      else begin
        order[pop_cnt] <= stack[sp - 1'b1];
        sp <= sp - 1'b1;
        pop_cnt <= pop_cnt + 1'b1;
      end
    end else if (state == SEND) idx <= idx + 1'b1;
endmodule

// File: tb/tb_train_dispatch.sv
// tb_train_dispatch: scoreboard bench for train_dispatch
module tb_train_dispatch;
  localparam int MAX_CARS = 10;
  localparam int DATA_W = 4;
  logic clk = 0, rst = 1, op_valid = 0, op = 0, op_last = 0;
  logic op_ready, tx_valid, done, err;
  logic [DATA_W-1:0] tx_data;
  int vectors = 0, miscompares = 0, cyc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = -1, err_cyc = -1, first_cyc = -1;
  bit seen_first = 0;
  int exp_q[$];
  bit q[$];
  train_dispatch #(.MAX_CARS(MAX_CARS), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_last(op_last),
    .op_ready(op_ready), .tx_valid(tx_valid), .tx_data(tx_data), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (tx_valid) begin
      if (!seen_first) begin
        seen_first = 1;
        first_cyc = cyc;
      end
      if (exp_q.size() == 0) chk("unexpected_beat", tx_valid, 0);
      else chk("beat", tx_data, exp_q.pop_front());
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end
  task automatic drive(input bit ops[$], input int gap, output int t);
    t = -1;
    foreach (ops[i]) begin
      repeat ($urandom_range(0, gap)) begin
        op_valid = 0;
        op = 1'($urandom_range(0, 1));
        op_last = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      op_valid = 1;
      op = ops[i];
      op_last = i == ops.size() - 1;
      if (op_last) t = cyc;
      @(posedge clk); #1;
    end
    op_valid = 0;
    op_last = 0;
  endtask
  task automatic run(input bit ops[$], input int gap);
    int stk[$], ord[$];
    int pc = 0, d0 = done_cnt, e0 = err_cnt, t;
    bit bad = 0;
    foreach (ops[i]) if (!bad) begin
      if (ops[i]) begin
        if (pc == MAX_CARS) bad = 1;
        else begin
          pc++;
          stk.push_back(pc);
        end
      end else if (stk.size() == 0) bad = 1;
      else ord.push_back(stk.pop_back());
    end
    if (stk.size() != 0 || pc == 0) bad = 1;
    if (!bad) begin
      exp_q.push_back(pc);
      foreach (ord[i]) exp_q.push_back(ord[i]);
    end
    seen_first = 0;
    drive(ops, gap, t);
    for (int i = 0; i < 40 && done_cnt == d0 && err_cnt == e0; i++) begin
      @(negedge clk); #1;
    end
    if (bad) begin
      chk("err_pulse", err_cnt - e0, 1);
      chk("err_cycle", err_cyc, t + 2);
      chk("no_done", done_cnt - d0, 0);
      chk("no_beats", int'(seen_first), 0);
    end else begin
      chk("done_pulse", done_cnt - d0, 1);
      chk("done_cycle", done_cyc, t + pc + 3);
      chk("first_beat_cycle", first_cyc, t + 2);
      chk("no_err", err_cnt - e0, 0);
      chk("beats_left", exp_q.size(), 0);
    end
    chk("ready_low", op_ready, 0);
    @(negedge clk); #1;
    chk("ready_back", op_ready, 1);
    chk("tx_idle", tx_valid, 0);
    @(posedge clk); #1;
  endtask
  task automatic rand_run();
    int n, p, s;
    n = $urandom_range(1, MAX_CARS);
    p = 0;
    s = 0;
    q = {};
    while (q.size() < 2 * n)
      if (p < n && (s == 0 || $urandom_range(0, 1) == 1)) begin
        q.push_back(1);
        p++;
        s++;
      end else begin
        q.push_back(0);
        s--;
      end
    run(q, 2);
  endtask
  initial begin
    int t;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_op_ready", op_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk); #1;
    rst = 0;
    q = '{1, 1, 0, 0, 1, 0};
    run(q, 0);
    q = '{1, 0};
    run(q, 1);
    q = '{0};
    run(q, 0);
    q = '{1, 1, 0, 1, 0, 0};
    run(q, 0);
    q = '{1, 1, 1, 0, 0};
    run(q, 0);
    q = {};
    repeat (MAX_CARS) q.push_back(1);
    repeat (MAX_CARS) q.push_back(0);
    run(q, 0);
    q = {};
    repeat (MAX_CARS + 1) q.push_back(1);
    repeat (MAX_CARS + 1) q.push_back(0);
    run(q, 0);
    q = '{1};
    run(q, 0);
    q = '{1, 1, 1, 0, 0, 0};
    exp_q.push_back(3);
    exp_q.push_back(3);
    drive(q, 0, t);
    while (cyc < t + 4) begin
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_tx_valid", tx_valid, 0);
    chk("post_rst_op_ready", op_ready, 1);
    chk("post_rst_beats_left", exp_q.size(), 0);
    exp_q = {};
    @(posedge clk); #1;
    q = '{1, 1, 0, 1, 0, 0};
    run(q, 0);
    repeat (500) rand_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
